// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory, decoder and execute-controller signals of the fetch stage
interface instr_fetch_unit_if #(parameter int ADDR_WIDTH = 10);
  logic                  start;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic [31:0]           instr;
  logic                  decode_en;
  logic [31:0]           pc;
  logic [31:0]           pc_plus4;
  logic                  step_done;
  logic                  branch_taken;
  logic [31:0]           branch_offset;
  logic                  jump;
  logic [25:0]           jump_address;
  logic                  jump_reg;
  logic [31:0]           jr_target;
  logic                  halted;
  logic                  fetch_err;
  logic [31:0]           instr_count;
  logic                  busy;
  modport master (
    input  start, imem_rdata, step_done, branch_taken, branch_offset, jump, jump_address, jump_reg, jr_target,
    output imem_en, imem_addr, instr, decode_en, pc, pc_plus4, halted, fetch_err, instr_count, busy
  );
  modport slave (
    output start, imem_rdata, step_done, branch_taken, branch_offset, jump, jump_address, jump_reg, jr_target,
    input  imem_en, imem_addr, instr, decode_en, pc, pc_plus4, halted, fetch_err, instr_count, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch stage owning the PC, BRAM read, issue pulse and redirects
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, EXEC, HALT} state_t;
  state_t      state;
  logic [31:0] next_pc;
  logic        jr_bad;
  assign bus.pc_plus4  = bus.pc + 32'd4;
  assign bus.imem_addr = bus.pc[ADDR_WIDTH+1:2];
  assign jr_bad        = bus.jump_reg && (bus.jr_target[1:0] != 2'b00);
  always_comb
    next_pc = bus.jump_reg     ? bus.jr_target :
              bus.jump         ? {bus.pc_plus4[31:28], bus.jump_address, 2'b00} :
              bus.branch_taken ? bus.pc_plus4 + (bus.branch_offset << 2) :
                                 bus.pc_plus4;
  // imem_en and decode_en are registered one-cycle pulses raised on the transition into their state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      bus.pc          <= RESET_PC;
      bus.instr       <= 32'd0;
      bus.decode_en   <= 1'b0;
      bus.imem_en     <= 1'b0;
      bus.halted      <= 1'b0;
      bus.fetch_err   <= 1'b0;
      bus.instr_count <= 32'd0;
      bus.busy        <= 1'b0;
    end else begin
      bus.imem_en   <= 1'b0;
      bus.decode_en <= 1'b0;
      case (state)
        IDLE, HALT:
          if (bus.start) begin
            state           <= FETCH;
            bus.pc          <= RESET_PC;
            bus.instr_count <= 32'd0;
            bus.fetch_err   <= 1'b0;
            bus.halted      <= 1'b0;
            bus.busy        <= 1'b1;
            bus.imem_en     <= 1'b1;
          end
        FETCH: state <= WAIT;
        WAIT: begin
          bus.instr <= bus.imem_rdata;
          if (bus.imem_rdata == HALT_WORD) begin
            state      <= HALT;
            bus.halted <= 1'b1;
            bus.busy   <= 1'b0;
          end else begin
            state         <= ISSUE;
            bus.decode_en <= 1'b1;
          end
        end
        ISSUE: state <= EXEC;
        EXEC:
          if (bus.step_done) begin
            if (jr_bad) begin
              state         <= HALT;
              bus.halted    <= 1'b1;
              bus.busy      <= 1'b0;
              bus.fetch_err <= 1'b1;
            end else begin
              state           <= FETCH;
              bus.pc          <= next_pc;
              bus.instr_count <= bus.instr_count + 32'd1;
              bus.imem_en     <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plan plus randomized run against a cycle-level behavioural model
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  logic started;
  logic [31:0] mem [1024];
  int n_chk, n_fail, dec_cnt;
  instr_fetch_unit_if bus ();
  instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  always @(negedge clk) if (bus.decode_en) dec_cnt++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: m_run = executing, m_t = cycles since the fetch began (3 = waiting for completion)
  logic        m_run, m_halt, m_err;
  int          m_t;
  logic [31:0] m_pc, m_cnt, m_instr;
  function automatic logic [31:0] target(input logic [31:0] p);
    logic [31:0] n = p + 32'd4;
    if (bus.jump_reg) return bus.jr_target;
    if (bus.jump) return (n & 32'hF000_0000) | (32'(bus.jump_address) << 2);
    if (bus.branch_taken) return n + bus.branch_offset * 32'd4;
    return n;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_run <= 1'b0; m_t <= 0; m_pc <= 32'd0; m_cnt <= 32'd0;
      m_err <= 1'b0; m_halt <= 1'b0; m_instr <= 32'd0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run <= 1'b1; m_t <= 0; m_pc <= 32'd0; m_cnt <= 32'd0; m_err <= 1'b0; m_halt <= 1'b0;
      end
    end else if (m_t == 0) m_t <= 1;
    else if (m_t == 1) begin
      m_instr <= mem[m_pc[11:2]];
      if (mem[m_pc[11:2]] == 32'hFFFF_FFFF) begin
        m_run <= 1'b0; m_halt <= 1'b1;
      end else m_t <= 2;
    end else if (m_t == 2) m_t <= 3;
    else if (bus.step_done) begin
      if (bus.jump_reg && (bus.jr_target % 4 != 0)) begin
        m_err <= 1'b1; m_halt <= 1'b1; m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 32'd1; m_t <= 0; m_pc <= target(m_pc);
      end
    end
  always @(negedge clk)
    if (started) begin
      check("imem_en", 32'(bus.imem_en), 32'(m_run && m_t == 0));
      check("imem_addr", 32'(bus.imem_addr), 32'(m_pc[11:2]));
      check("decode_en", 32'(bus.decode_en), 32'(m_run && m_t == 2));
      check("busy", 32'(bus.busy), 32'(m_run));
      check("halted", 32'(bus.halted), 32'(m_halt));
      check("fetch_err", 32'(bus.fetch_err), 32'(m_err));
      check("instr_count", bus.instr_count, m_cnt);
      check("pc", bus.pc, m_pc);
      check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      check("instr", bus.instr, m_instr);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.start = 0; bus.step_done = 0; bus.branch_taken = 0; bus.branch_offset = 0;
    bus.jump = 0; bus.jump_address = 0; bus.jump_reg = 0; bus.jr_target = 0;
  endtask
  task automatic step(input logic jr, input logic [31:0] jt, input logic j, input logic [25:0] ja,
                      input logic b, input logic [31:0] bo);
    bus.step_done = 1; bus.jump_reg = jr; bus.jr_target = jt; bus.jump = j;
    bus.jump_address = ja; bus.branch_taken = b; bus.branch_offset = bo;
    tick;
    clear_in;
  endtask
  task automatic wait_decode;
    for (int k = 0; k < 50 && !bus.decode_en; k++) tick;
    check("decode_wait", 32'(bus.decode_en), 32'd1);
  endtask
  task automatic exec_step(input logic jr, input logic [31:0] jt, input logic j, input logic [25:0] ja,
                           input logic b, input logic [31:0] bo);
    wait_decode;
    tick;
    step(jr, jt, j, ja, b, bo);
  endtask
  task automatic wait_halt;
    for (int k = 0; k < 50 && !bus.halted; k++) tick;
    check("halt_wait", 32'(bus.halted), 32'd1);
  endtask
  task automatic do_start;
    bus.start = 1;
    tick;
    bus.start = 0;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, bus.pc, 32'd0);
    check({tag, "_decode_en"}, 32'(bus.decode_en), 32'd0);
    check({tag, "_imem_en"}, 32'(bus.imem_en), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_count"}, bus.instr_count, 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask
  initial begin
    n_chk = 0; n_fail = 0; dec_cnt = 0; started = 0;
    rst = 1;
    clear_in;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2008_0005 ^ (i << 8);
    mem[3] = 32'hFFFF_FFFF;
    tick;
    started = 1;
    tick;
    rst = 0;
    tick;
    check_reset_vals("reset");
    do_start;
    check("t1_imem_en", 32'(bus.imem_en), 32'd1);
    check("t1_addr", 32'(bus.imem_addr), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick;
    check("t1_decode_early", 32'(bus.decode_en), 32'd0);
    tick;
    check("t1_decode", 32'(bus.decode_en), 32'd1);
    check("t1_instr", bus.instr, 32'h2008_0005);
    check("t1_pc", bus.pc, 32'd0);
    tick;
    check("t1_decode_late", 32'(bus.decode_en), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    exec_step(0, 0, 0, 0, 0, 0);
    exec_step(0, 0, 0, 0, 0, 0);
    wait_halt;
    check("t2_decodes", 32'(dec_cnt), 32'd3);
    check("t2_count", bus.instr_count, 32'd3);
    check("t2_pc", bus.pc, 32'd12);
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_instr", bus.instr, 32'hFFFF_FFFF);
    do_start;
    check("t3_pc0", bus.pc, 32'd0);
    check("t3_halted", 32'(bus.halted), 32'd0);
    exec_step(0, 0, 0, 0, 0, 0);
    exec_step(0, 0, 0, 0, 0, 0);
    exec_step(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    check("t3_beq_pc", bus.pc, 32'd4);
    check("t3_beq_fetch", 32'(bus.imem_en), 32'd1);
    check("t3_beq_addr", 32'(bus.imem_addr), 32'd1);
    exec_step(0, 0, 1, 26'h10, 0, 0);
    check("t3_j_pc", bus.pc, 32'h40);
    exec_step(1, 32'h20, 1, 26'h3, 1, 32'd5);
    check("t4_prio_pc", bus.pc, 32'h20);
    check("t4_prio_count", bus.instr_count, 32'd5);
    exec_step(1, 32'h22, 0, 0, 0, 0);
    check("t4_err", 32'(bus.fetch_err), 32'd1);
    check("t4_halted", 32'(bus.halted), 32'd1);
    check("t4_pc", bus.pc, 32'h20);
    check("t4_count", bus.instr_count, 32'd5);
    do_start;
    check("t5_pc", bus.pc, 32'd0);
    check("t5_count", bus.instr_count, 32'd0);
    check("t5_err", 32'(bus.fetch_err), 32'd0);
    check("t5_refetch", 32'(bus.imem_en), 32'd1);
    bus.step_done = 1;
    repeat (3) tick;
    bus.step_done = 0;
    check("t5_early_pc", bus.pc, 32'd0);
    check("t5_early_count", bus.instr_count, 32'd0);
    bus.start = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t5_start_exec", 32'(bus.imem_en), 32'd0);
    end
    bus.start = 0;
    check("t5_busy", 32'(bus.busy), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("t5_step_pc", bus.pc, 32'd4);
    check("t5_step_count", bus.instr_count, 32'd1);
    wait_decode;
    tick;
    tick;
    rst = 1;
    #1;
    check_reset_vals("t6_exec");
    tick;
    rst = 0;
    do_start;
    wait_decode;
    rst = 1;
    #1;
    check_reset_vals("t6_issue");
    tick;
    rst = 0;
    do_start;
    wait_decode;
    check("t6_pc", bus.pc, 32'd0);
    check("t6_instr", bus.instr, 32'h2008_0005);
    rst = 1;
    tick;
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom % 16 == 0) ? 32'hFFFF_FFFF : $urandom;
    rst = 0;
    for (int c = 0; c < 5000; c++) begin
      bus.start = ($urandom % 8 == 0);
      bus.step_done = ($urandom % 3 == 0);
      bus.jump_reg = ($urandom % 8 == 0);
      bus.jr_target = $urandom;
      if ($urandom % 5 != 0) bus.jr_target[1:0] = 2'b00;
      bus.jump = ($urandom % 6 == 0);
      bus.jump_address = 26'($urandom);
      bus.branch_taken = ($urandom % 4 == 0);
      bus.branch_offset = $urandom;
      rst = ($urandom % 300 == 0);
      tick;
    end
    rst = 0;
    clear_in;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multicycle instruction fetch stage that sits directly upstream of the instruction decoder/control block. It owns the program counter and reads the synchronous instruction memory (BRAM, 1-cycle read latency). It presents a registered instruction with a one-cycle decode-enable pulse, then waits for the execute controller to report completion together with branch/jump/jr redirect information. It computes the next PC, counts retired instructions, and detects the halt word and misaligned jr targets.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory (1024 words)
RESET_PC, 32'h00000000, PC value after reset and on every start
HALT_WORD, 32'hFFFFFFFF, fetched word that stops execution

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin or restart execution; sampled in IDLE or HALT only
imem_en  out  1  instruction memory read enable, high for exactly one cycle per fetch
imem_addr  out  ADDR_WIDTH  word address = pc[ADDR_WIDTH+1:2]
imem_rdata  in  32  memory data, valid the cycle after imem_en
instr  out  32  registered instruction; drives decoder instr
decode_en  out  1  one-cycle pulse; drives decoder en
pc  out  32  address of the current instruction
pc_plus4  out  32  pc+4, combinational; jal link value
step_done  in  1  controller: current instruction finished
branch_taken  in  1  beq condition met
branch_offset  in  32  sign-extended immediate from decoder
jump  in  1  j/jal
jump_address  in  26  decoder jump_address field
jump_reg  in  1  jr
jr_target  in  32  rs register value for jr
halted  out  1  high in HALT state
fetch_err  out  1  sticky; set by misaligned jr target
instr_count  out  32  retired instruction count
busy  out  1  high in any state other than IDLE/HALT

Behaviour:
- Reset (async, any state):
  - state=IDLE, pc=RESET_PC, instr=0, decode_en=0, imem_en=0, halted=0, fetch_err=0, instr_count=0.
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALT.
- IDLE:
  - start=1 -> FETCH, pc<=RESET_PC, instr_count<=0, fetch_err<=0.
- FETCH:
  - imem_en=1, imem_addr from the current pc -> WAIT.
- WAIT:
  - instr<=imem_rdata.
  - If imem_rdata==HALT_WORD -> HALT; the halt word is not issued and not counted.
  - Otherwise -> ISSUE.
- ISSUE:
  - decode_en=1 for this cycle only -> EXEC.
- EXEC:
  - Wait indefinitely for step_done. instr and pc are held stable.
  - On step_done: pc<=next_pc, instr_count<=instr_count+1 (wraps at 2^32) -> FETCH.
- next_pc priority, first match wins:
  1. jump_reg: jr_target. If jr_target[1:0]!=0, set fetch_err, go to HALT, leave pc unchanged, and do not increment instr_count.
  2. jump: {pc_plus4[31:28], jump_address, 2'b00}.
  3. branch_taken: pc_plus4 + (branch_offset<<2), 32-bit wrap.
  4. Otherwise pc_plus4.
- Redirect inputs are sampled only in the cycle step_done=1 in EXEC.
- HALT:
  - halted=1, pc holds the halt word's address (or the jr instruction's address on error).
  - start=1 restarts exactly as from IDLE; halted clears.
- Ignored inputs:
  - step_done outside EXEC.
  - start outside IDLE/HALT.
- Address wrap: imem_addr truncates pc. Upper pc bits are kept in pc but do not affect the memory address.
- Timing:
  - start sampled in cycle 0 -> imem_en cycle 1 -> instr updated end of cycle 2 -> decode_en cycle 3.
  - step_done in cycle N -> next imem_en in cycle N+1.
  - Minimum 4 cycles per instruction.
- busy=1 in FETCH/WAIT/ISSUE/EXEC.
- Mid-operation reset: async rst in any state, including with decode_en high, returns all outputs to reset values immediately. decode_en must never be left high.

Test Plan:
- Reset then start at cycle 0, mem[0]=32'h20080005 -> imem_en=1 cycle 1 (addr 0), decode_en=1 cycle 3 only, instr=32'h20080005, pc=0, busy=1.
- Sequential: three step_done pulses with no redirects, mem[3]=HALT_WORD -> pc 0,4,8,12; halted=1, instr_count=3, pc=12, decode_en pulsed exactly 3 times.
- Backward beq at pc=8, branch_offset=32'hFFFFFFFE, branch_taken=1 -> next imem_addr=1, pc=4. Then j at pc=4 with jump_address=26'h10 -> pc=32'h40.
- Priority: step_done with jump_reg=1 (jr_target=32'h20), jump=1, branch_taken=1 all set -> pc=32'h20. Then jr_target=32'h22 -> fetch_err=1, halted=1, pc unchanged, instr_count not incremented.
- step_done asserted during FETCH/WAIT/ISSUE and start during EXEC -> no effect on pc or instr_count, no extra imem_en. start in HALT -> pc=RESET_PC, instr_count=0, fetch_err=0, refetch.
- rst asserted mid-EXEC and again during the ISSUE cycle -> outputs return to reset values the same cycle, decode_en=0; a subsequent start refetches from RESET_PC.
